// File: rtl/array_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : array_drain_pkg
//  Description : Shared types, constants and the output-word packing helper
//                for the systolic-array result drain.
//  Contents    : drain_state_t  - drain controller states
//                RES_W, NUM_PE, IDX_W, OUT_W, FLUSH_CNT_W - sizing constants
//                pack_out_word  - builds {index, zero pad, result}
//  Revision    : 1.0 - initial release
// ============================================================================
package array_drain_pkg;

    localparam int DATA_SIZE   = 8;
    localparam int RES_W       = 2*DATA_SIZE + 1;
    localparam int NUM_PE      = 16;
    localparam int IDX_W       = 4;
    localparam int OUT_W       = 32;
    localparam int FLUSH_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        CLEAR = 3'd4
    } drain_state_t;

    // Index in the top nibble, result zero-extended into the low bits.
    function automatic logic [OUT_W-1:0] pack_out_word(
        input logic [IDX_W-1:0] idx,
        input logic [RES_W-1:0] res
    );
        return {idx, {(OUT_W-IDX_W-RES_W){1'b0}}, res};
    endfunction

endpackage
`default_nettype wire

// File: rtl/array_result_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : array_result_drain_if
//  Description : Valid/ready result stream carrying one packed accumulator
//                word per transfer.
//  Signals     : out_valid - word available (producer)
//                out_ready - word accepted   (consumer)
//                out_data  - packed {index, pad, result} word (producer)
//                out_last  - final word of the tile (producer)
//  Modports    : master (producer side), slave (consumer side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface array_result_drain_if;
    import array_drain_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/result_snapshot_buf.sv
`default_nettype none
// ============================================================================
//  Module      : result_snapshot_buf
//  Description : NUM_PE x RES_W register bank. All entries are loaded in the
//                single cycle where capture is high; rd_data is a plain mux
//                of the held entries selected by rd_idx (0 when out of range).
//  Ports       : clk, resetn  - clock, asynchronous active-low reset
//                capture      - load every entry from results
//                results      - flattened accumulators, entry k at [RES_W*k +: RES_W]
//                rd_idx       - entry select
//                rd_data      - selected entry
//  Revision    : 1.0 - initial release
// ============================================================================
module result_snapshot_buf #(
    parameter int RES_W  = 17,
    parameter int NUM_PE = 16,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    capture,
    input  logic [NUM_PE*RES_W-1:0] results,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [RES_W-1:0]        rd_data
);

    logic [RES_W-1:0] bank [NUM_PE];

    for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                bank[g] <= '0;
            end else if (capture) begin
                bank[g] <= results[RES_W*g +: RES_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = bank[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/array_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : array_result_drain
//  Description : Watches the operand feed phase, waits FLUSH_CYCLES edges for
//                the skewed wavefront to settle, snapshots every accumulator
//                in one cycle, streams them as 32-bit words over valid/ready,
//                then pulses acc_clear once the last word is accepted.
//  Ports       : clk, resetn   - clock, asynchronous active-low reset
//                feed_active   - operand delivery in progress
//                results       - flattened accumulators, PE k at [RES_W*k +: RES_W]
//                out_if        - result stream (master side)
//                acc_clear     - one-cycle accumulator clear request
//                busy          - controller not idle
//                overrun       - sticky: a feed started while a tile was in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module array_result_drain #(
    parameter int DATA_SIZE    = 8,
    parameter int NUM_PE       = 16,
    parameter int FLUSH_CYCLES = 10
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                feed_active,
    input  logic [NUM_PE*(2*DATA_SIZE+1)-1:0]   results,
    array_result_drain_if.master                out_if,
    output logic                                acc_clear,
    output logic                                busy,
    output logic                                overrun
);

    localparam int RES_W = 2*DATA_SIZE + 1;

    import array_drain_pkg::*;

    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_PE - 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    drain_state_t           state;
    drain_state_t           state_nxt;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt_nxt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_nxt;

    logic                   out_valid_q;
    logic [OUT_W-1:0]       out_data_q;
    logic                   out_last_q;
    logic [OUT_W-1:0]       out_data_nxt;
    logic                   out_last_nxt;

    logic                   capture;
    logic                   accept;
    logic [IDX_W-1:0]       rd_idx;
    logic [RES_W-1:0]       rd_data;

    // The buffer is read one entry ahead so the word following an accepted
    // one can be registered on the same edge as the acceptance.
    assign rd_idx = idx + IDX_W'(1);

    result_snapshot_buf #(
        .RES_W  (RES_W),
        .NUM_PE (NUM_PE),
        .IDX_W  (IDX_W)
    ) u_snap (
        .clk     (clk),
        .resetn  (resetn),
        .capture (capture),
        .results (results),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        idx_nxt       = idx;
        capture       = 1'b0;
        accept        = (state == DRAIN) && out_if.out_ready;
        out_data_nxt  = out_data_q;
        out_last_nxt  = out_last_q;

        case (state)
            IDLE: begin
                if (feed_active) begin
                    state_nxt = FEED;
                end
            end
            FEED: begin
                if (!feed_active) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt != '0) begin
                    flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
                end else begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = DRAIN;
                    // Bank is loading on this same edge, so word 0 is
                    // taken straight from the live accumulators.
                    out_data_nxt = pack_out_word('0, results[RES_W-1:0]);
                    out_last_nxt = (LAST_IDX == '0);
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        state_nxt    = CLEAR;
                        out_data_nxt = '0;
                        out_last_nxt = 1'b0;
                    end else begin
                        idx_nxt      = rd_idx;
                        out_data_nxt = pack_out_word(rd_idx, rd_data);
                        out_last_nxt = (rd_idx == LAST_IDX);
                    end
                end
            end
            CLEAR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            idx         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            acc_clear   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_cnt   <= flush_cnt_nxt;
            idx         <= idx_nxt;
            out_valid_q <= (state_nxt == DRAIN);
            out_data_q  <= out_data_nxt;
            out_last_q  <= out_last_nxt;
            acc_clear   <= (state_nxt == CLEAR);
            busy        <= (state_nxt != IDLE);
            // A feed arriving before the previous tile is fully drained is
            // flagged but otherwise ignored; the tile in flight completes.
            if (feed_active && ((state == FLUSH) || (state == DRAIN) || (state == CLEAR))) begin
                overrun <= 1'b1;
            end
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_array_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_result_drain
//  Description : Self-checking bench for array_result_drain. A behavioural
//                model records the accumulator values present at the snapshot
//                edge and predicts the packed word stream from them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_array_result_drain;

    localparam int NPE   = 16;
    localparam int RW    = 17;
    localparam int FLUSH = 10;

    logic              clk;
    logic              resetn;
    logic              feed_active;
    logic [NPE*RW-1:0] results;
    logic              acc_clear;
    logic              busy;
    logic              overrun;

    logic [RW-1:0]     cur [NPE];
    logic [RW-1:0]     snap_model [NPE];

    int checks;
    int errors;

    logic [31:0] obs_data [$];
    logic        obs_last [$];
    int          stall_bad;
    int          clr_seen;
    int          coll_cycles;
    bit          timed_out;

    array_result_drain_if dif ();

    array_result_drain #(
        .DATA_SIZE    (8),
        .NUM_PE       (NPE),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .feed_active (feed_active),
        .results     (results),
        .out_if      (dif),
        .acc_clear   (acc_clear),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        results = '0;
        for (int k = 0; k < NPE; k++) begin
            results[k*RW +: RW] = cur[k];
        end
    end

    // Expected word: PE index weighted into bits 31:28 plus the raw result.
    function automatic logic [31:0] model_word(input int k);
        return 32'(k) * 32'h1000_0000 + 32'(snap_model[k]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < NPE; k++) begin
            case (mode)
                0:       cur[k] = RW'(k*1000 + 1);
                1:       cur[k] = 17'h1FFFF;
                default: cur[k] = RW'($urandom);
            endcase
        end
    endtask

    // Runs a feed of len cycles, then the flush interval; returns just before
    // the snapshot edge with snap_model holding what that edge will capture.
    task automatic feed_and_flush(input int len, input int mode, input bit churn);
        fill(mode);
        feed_active = 1'b1;
        repeat (len) begin
            if (churn) fill(2);
            tick();
        end
        feed_active = 1'b0;
        repeat (FLUSH) begin
            if (churn) fill(2);
            tick();
        end
        if (churn) fill(2);
        for (int k = 0; k < NPE; k++) snap_model[k] = cur[k];
    endtask

    // Drives out_ready per rmode and records accepted words until the last
    // word or max_words. rmode 0: always ready, 1: ready every third cycle,
    // 2: random. pulse_at >= 0 raises feed_active for one cycle once that
    // many words have been accepted.
    task automatic collect(input int rmode, input bit churn, input int pulse_at, input int max_words);
        logic        v, l, pl, rdy;
        logic [31:0] d, pd;
        bit          pstall, pulsed;
        int          cyc;
        obs_data.delete();
        obs_last.delete();
        stall_bad = 0;
        clr_seen  = 0;
        timed_out = 0;
        pstall    = 0;
        pulsed    = 0;
        pd        = '0;
        pl        = 1'b0;
        cyc       = 0;
        while (1) begin
            v = dif.out_valid;
            d = dif.out_data;
            l = dif.out_last;
            if (pstall && (v !== 1'b1 || d !== pd || l !== pl)) stall_bad++;
            if (acc_clear) clr_seen++;
            if (cyc > 400) begin
                timed_out = 1;
                break;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (pulse_at >= 0 && !pulsed && obs_data.size() == pulse_at) begin
                feed_active = 1'b1;
                pulsed = 1;
            end else begin
                feed_active = 1'b0;
            end
            dif.out_ready = rdy;
            if (churn) fill(2);
            tick();
            cyc++;
            if (v && rdy) begin
                obs_data.push_back(d);
                obs_last.push_back(l);
                if (l || obs_data.size() == max_words) break;
            end
            pstall = v && !rdy;
            pd = d;
            pl = l;
        end
        coll_cycles   = cyc;
        dif.out_ready = 1'b0;
        feed_active   = 1'b0;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        feed_active   = 1'b0;
        dif.out_ready = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        checks++;
        if ({dif.out_valid, dif.out_last, acc_clear, busy, overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got v/l/clr/busy/ovr=%b expected 00000",
                     {dif.out_valid, dif.out_last, acc_clear, busy, overrun});
        end
        checks++;
        if (dif.out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00000000", dif.out_data);
        end
    endtask

    task automatic test_basic();
        feed_and_flush(7, 0, 0);
        checks++;
        if (dif.out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_pre_snapshot: got valid=%b busy=%b expected valid=0 busy=1", dif.out_valid, busy);
        end
        tick();
        checks++;
        if (dif.out_valid !== 1'b1 || dif.out_data !== model_word(0) || dif.out_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_word: got v=%b d=%h l=%b expected v=1 d=%h l=0",
                     dif.out_valid, dif.out_data, dif.out_last, model_word(0));
        end
        collect(0, 0, -1, NPE);
        checks++;
        if (timed_out || obs_data.size() != NPE || coll_cycles != NPE) begin
            errors++;
            $display("FAIL basic_count: got words=%0d cycles=%0d timeout=%0d expected 16/16/0",
                     obs_data.size(), coll_cycles, timed_out);
        end
        for (int k = 0; k < obs_data.size() && k < NPE; k++) begin
            checks++;
            if (obs_data[k] !== model_word(k) || obs_last[k] !== (k == NPE-1)) begin
                errors++;
                $display("FAIL basic_word%0d: got %h last=%b expected %h last=%b",
                         k, obs_data[k], obs_last[k], model_word(k), (k == NPE-1));
            end
        end
        checks++;
        if (acc_clear !== 1'b1 || dif.out_valid !== 1'b0 || busy !== 1'b1 || clr_seen != 0) begin
            errors++;
            $display("FAIL basic_clear_pulse: got clr=%b valid=%b busy=%b early_clr=%0d expected 1/0/1/0",
                     acc_clear, dif.out_valid, busy, clr_seen);
        end
        tick();
        checks++;
        if (acc_clear !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got clr=%b busy=%b ovr=%b expected 0/0/0", acc_clear, busy, overrun);
        end
    endtask

    task automatic test_all_ones();
        feed_and_flush(3, 1, 0);
        tick();
        collect(0, 0, -1, NPE);
        checks++;
        if (timed_out || obs_data.size() != NPE) begin
            errors++;
            $display("FAIL ones_count: got %0d words timeout=%0d expected 16", obs_data.size(), timed_out);
        end
        for (int k = 0; k < obs_data.size() && k < NPE; k++) begin
            checks++;
            if (obs_data[k][16:0] !== 17'h1FFFF || obs_data[k][27:17] !== 11'h0 || obs_data[k] !== model_word(k)) begin
                errors++;
                $display("FAIL ones_word%0d: got %h expected %h", k, obs_data[k], model_word(k));
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        feed_and_flush(5, 0, 0);
        tick();
        collect(1, 0, -1, NPE);
        checks++;
        if (timed_out || obs_data.size() != NPE || stall_bad != 0 || coll_cycles != 46) begin
            errors++;
            $display("FAIL bp_stream: got words=%0d stall_errs=%0d cycles=%0d expected 16/0/46",
                     obs_data.size(), stall_bad, coll_cycles);
        end
        for (int k = 0; k < obs_data.size() && k < NPE; k++) begin
            checks++;
            if (obs_data[k] !== model_word(k) || obs_last[k] !== (k == NPE-1)) begin
                errors++;
                $display("FAIL bp_word%0d: got %h last=%b expected %h", k, obs_data[k], obs_last[k], model_word(k));
            end
        end
        tick();
    endtask

    task automatic test_result_churn();
        feed_and_flush(5, 2, 1);
        tick();
        collect(2, 1, -1, NPE);
        checks++;
        if (timed_out || obs_data.size() != NPE || stall_bad != 0) begin
            errors++;
            $display("FAIL churn_stream: got words=%0d stall_errs=%0d expected 16/0", obs_data.size(), stall_bad);
        end
        for (int k = 0; k < obs_data.size() && k < NPE; k++) begin
            checks++;
            if (obs_data[k] !== model_word(k)) begin
                errors++;
                $display("FAIL churn_word%0d: got %h expected %h", k, obs_data[k], model_word(k));
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL churn_idle: got busy=%b ovr=%b expected 0/0", busy, overrun);
        end
    endtask

    task automatic test_short_feed();
        feed_and_flush(1, 2, 0);
        checks++;
        if (dif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_pre_snapshot: got valid=%b expected 0", dif.out_valid);
        end
        tick();
        collect(2, 0, -1, NPE);
        checks++;
        if (timed_out || obs_data.size() != NPE) begin
            errors++;
            $display("FAIL short_count: got %0d words expected 16", obs_data.size());
        end
        for (int k = 0; k < obs_data.size() && k < NPE; k++) begin
            checks++;
            if (obs_data[k] !== model_word(k)) begin
                errors++;
                $display("FAIL short_word%0d: got %h expected %h", k, obs_data[k], model_word(k));
            end
        end
        tick();
    endtask

    task automatic test_overrun();
        feed_and_flush(4, 0, 0);
        tick();
        collect(0, 0, 3, NPE);
        checks++;
        if (timed_out || obs_data.size() != NPE || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drain: got words=%0d ovr=%b expected 16/1", obs_data.size(), overrun);
        end
        for (int k = 0; k < obs_data.size() && k < NPE; k++) begin
            checks++;
            if (obs_data[k] !== model_word(k)) begin
                errors++;
                $display("FAIL ovr_word%0d: got %h expected %h", k, obs_data[k], model_word(k));
            end
        end
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_no_refeed: got busy=%b ovr=%b expected 0/1", busy, overrun);
        end
        feed_and_flush(3, 2, 0);
        tick();
        collect(2, 0, -1, NPE);
        checks++;
        if (timed_out || obs_data.size() != NPE || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_next_tile: got words=%0d ovr=%b expected 16/1", obs_data.size(), overrun);
        end
        for (int k = 0; k < obs_data.size() && k < NPE; k++) begin
            checks++;
            if (obs_data[k] !== model_word(k)) begin
                errors++;
                $display("FAIL ovr_next_word%0d: got %h expected %h", k, obs_data[k], model_word(k));
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        feed_and_flush(6, 2, 0);
        tick();
        collect(0, 0, -1, 5);
        checks++;
        if (obs_data.size() != 5 || dif.out_valid !== 1'b1 || dif.out_data !== model_word(5)) begin
            errors++;
            $display("FAIL rst_partial: got words=%0d v=%b d=%h expected 5/1/%h",
                     obs_data.size(), dif.out_valid, dif.out_data, model_word(5));
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({dif.out_valid, dif.out_last, acc_clear, busy, overrun} !== 5'b0 || dif.out_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: got v/l/clr/busy/ovr=%b d=%h expected 00000/00000000",
                     {dif.out_valid, dif.out_last, acc_clear, busy, overrun}, dif.out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (acc_clear !== 1'b0 || busy !== 1'b0 || dif.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_quiet%0d: got clr=%b busy=%b valid=%b expected 0/0/0",
                         i, acc_clear, busy, dif.out_valid);
            end
        end
        feed_and_flush(2, 0, 0);
        tick();
        collect(0, 0, -1, NPE);
        checks++;
        if (timed_out || obs_data.size() != NPE) begin
            errors++;
            $display("FAIL rst_fresh_count: got %0d words expected 16", obs_data.size());
        end
        for (int k = 0; k < obs_data.size() && k < NPE; k++) begin
            checks++;
            if (obs_data[k] !== model_word(k)) begin
                errors++;
                $display("FAIL rst_fresh_word%0d: got %h expected %h", k, obs_data[k], model_word(k));
            end
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_all_ones();
        test_backpressure();
        test_result_churn();
        test_short_feed();
        test_overrun();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
